mux_4way_16: RTL and testbench

- Registered 4-input, 16-bit-wide word multiplexer for the Hack-style datapath (NAND-to-FPGA project 1 gate library).
- Selects one of four data words a/b/c/d by a 2-bit select and presents it on out.
- out is registered on the clock, so consumers see a glitch-free, timing-closed value one cycle after inputs settle.
- Leaf block, used by the ALU/CPU path and by mux8way16 (two instances plus a mux2way16 stage).

---
 rtl/hack_gates_pkg.sv | 20 ++
 rtl/mux2way16.sv | 23 ++
 rtl/mux_4way_16.sv | 63 ++++++
 tb/tb_mux_4way_16.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/hack_gates_pkg.sv
// ============================================================================
// Module      : hack_gates_pkg
// Description : Shared width default and word-select codes for the Hack
//               gate library.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hack_gates_pkg;

    localparam int WORD_W = 16;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage : hack_gates_pkg

`default_nettype wire

// File: rtl/mux2way16.sv
// ============================================================================
// Module      : mux2way16
// Description : Combinational 2:1 word multiplexer, out = sel ? y : x.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2way16
    import hack_gates_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? y : x;

endmodule : mux2way16

`default_nettype wire

// File: rtl/mux_4way_16.sv
// ============================================================================
// Module      : mux_4way_16
// Description : Registered 4:1 word multiplexer built as a two-level tree of
//               mux2way16 stages feeding an async-reset output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4way_16
    import hack_gates_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] w_ab;
    logic [WIDTH-1:0] w_cd;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_out;

    // Level 0: sel[0] chooses within each pair; level 1: sel[1] chooses the pair.
    mux2way16 #(.WIDTH(WIDTH)) u_mux_ab (
        .x   (a),
        .y   (b),
        .sel (sel[0]),
        .out (w_ab)
    );

    mux2way16 #(.WIDTH(WIDTH)) u_mux_cd (
        .x   (c),
        .y   (d),
        .sel (sel[0]),
        .out (w_cd)
    );

    mux2way16 #(.WIDTH(WIDTH)) u_mux_top (
        .x   (w_ab),
        .y   (w_cd),
        .sel (sel[1]),
        .out (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_next;
        end
    end

    assign out = r_out;

endmodule : mux_4way_16

`default_nettype wire

// File: tb/tb_mux_4way_16.sv
// ============================================================================
// Module      : tb_mux_4way_16
// Description : Scoreboard bench for mux_4way_16 at WIDTH=16 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_4way_16;
    import hack_gates_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b, c, d, out16;
    logic [1:0]  sel;
    logic [7:0]  a8, b8, c8, d8, out8;
    logic [1:0]  sel8;

    logic [15:0] q16[$];
    logic [7:0]  q8[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mux_4way_16 #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .sel(sel), .out(out16)
    );

    mux_4way_16 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .d(d8), .sel(sel8), .out(out8)
    );

    // Reference: the select code is simply an index into the list of words.
    function automatic logic [63:0] ref_word(input logic [63:0] w0, w1, w2, w3,
                                             input logic [1:0] s);
        logic [63:0] words[4];
        words = '{w0, w1, w2, w3};
        return words[s];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive both DUTs at a negedge, record expectations, move to the next negedge.
    task automatic apply(input logic [15:0] ia, ib, ic, id, input logic [1:0] is,
                         input logic [7:0] ja, jb, jc, jd, input logic [1:0] js);
        a = ia; b = ib; c = ic; d = id; sel = is;
        a8 = ja; b8 = jb; c8 = jc; d8 = jd; sel8 = js;
        q16.push_back(16'(ref_word(64'(ia), 64'(ib), 64'(ic), 64'(id), is)));
        q8.push_back(8'(ref_word(64'(ja), 64'(jb), 64'(jc), 64'(jd), js)));
        @(negedge clk);
    endtask

    task automatic apply16(input logic [15:0] ia, ib, ic, id, input logic [1:0] is);
        apply(ia, ib, ic, id, is, 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 2'($urandom));
    endtask

    // Monitor: every capture edge, compare whatever is pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q16.size() > 0) chk("out16", 64'(out16), 64'(q16.pop_front()));
            if (q8.size() > 0)  chk("out8",  64'(out8),  64'(q8.pop_front()));
        end
    end

    initial begin
        logic [15:0] sweep_exp[4];
        logic [7:0]  w8[4];

        rst_n = 1'b1;
        a = '0; b = '0; c = '0; d = '0; sel = '0;
        a8 = '0; b8 = '0; c8 = '0; d8 = '0; sel8 = '0;

        // Reset asserted mid-cycle.
        #3;
        a = 16'hAAAA; b = 16'h5555; c = 16'hFFFF; d = 16'h0000; sel = SEL_A;
        rst_n = 1'b0;
        #1;
        chk("reset_immediate16", 64'(out16), 64'h0);
        chk("reset_immediate8",  64'(out8),  64'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold16", 64'(out16), 64'h0);
            chk("reset_hold8",  64'(out8),  64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Select sweep on the reference data.
        apply16(16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, SEL_A);
        apply16(16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, SEL_B);
        apply16(16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, SEL_C);
        apply16(16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, SEL_D);
        sweep_exp = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};

        // Latency: selected word changes between edges.
        apply16(16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, SEL_B);
        b = 16'h1234;
        #1;
        chk("latency_hold", 64'(out16), 64'(sweep_exp[1]));
        apply16(16'hAAAA, 16'h1234, 16'hFFFF, 16'h0000, SEL_B);

        // Non-selected words churn while sel holds B.
        for (int i = 0; i < 6; i++)
            apply16(16'($urandom), 16'h1234, 16'($urandom), 16'($urandom), SEL_B);

        // Async reset mid-stream with out = FFFF.
        apply16(16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, SEL_C);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_immediate", 64'(out16), 64'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("midreset_hold", 64'(out16), 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply16(16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, SEL_C);

        // Bit independence with one-hot words.
        for (int s = 0; s < 4; s++)
            apply16(16'h0001, 16'h0002, 16'h0004, 16'h8000, 2'(s));

        // WIDTH=8 sweep.
        w8 = '{8'hAA, 8'h55, 8'hFF, 8'h00};
        for (int s = 0; s < 4; s++)
            apply(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
                  w8[0], w8[1], w8[2], w8[3], 2'(s));

        // Randomized traffic on both widths.
        for (int i = 0; i < 200; i++)
            apply(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));

        @(posedge clk);
        #3;
        chk("drain16", 64'(q16.size()), 64'h0);
        chk("drain8",  64'(q8.size()),  64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux_4way_16

`default_nettype wire
